// File: rtl/async_fifo_gray.sv
// Dual-clock FIFO with Gray-coded pointer crossing and per-domain reset sync.
// Registered full/empty/count flags; overflow/underflow flag a refused request.
module async_fifo_gray #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = 6,
  parameter int AEMPTY_TH   = 1
) (
  input  logic              write_clk,
  input  logic              read_clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow,
  input  logic              read_en,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_count,
  output logic              underflow
);

  localparam int PW = ADDR_W + 1;
  localparam int S  = SYNC_STAGES;
  localparam logic [ADDR_W:0] INV   = PW'(3) << (ADDR_W - 1);
  localparam logic [ADDR_W:0] AF_TH = PW'(AFULL_TH);
  localparam logic [ADDR_W:0] AE_TH = PW'(AEMPTY_TH);

  function automatic logic [ADDR_W:0] b2g(input logic [ADDR_W:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ADDR_W:0] g2b(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [S-1:0] wrst_q, rrst_q;
  logic         w_rst_n, r_rst_n;

  always_ff @(posedge write_clk or negedge reset)
    if (!reset) wrst_q <= '0;
    else        wrst_q <= {wrst_q[S-2:0], 1'b1};

  always_ff @(posedge read_clk or negedge reset)
    if (!reset) rrst_q <= '0;
    else        rrst_q <= {rrst_q[S-2:0], 1'b1};

  assign w_rst_n = wrst_q[S-1];
  assign r_rst_n = rrst_q[S-1];

  logic [ADDR_W:0] wbin, wgray, wbin_nx, wgray_nx, wcnt_nx;
  logic [ADDR_W:0] rbin, rgray, rbin_nx, rgray_nx, rcnt_nx;
  logic [S-1:0][ADDR_W:0] rq, wq;
  logic w_inc, r_inc;

  always_comb begin
    w_inc    = write_en & ~full;
    wbin_nx  = wbin + {{ADDR_W{1'b0}}, w_inc};
    wgray_nx = b2g(wbin_nx);
    wcnt_nx  = wbin_nx - g2b(rq[S-1]);
  end

  always_ff @(posedge write_clk)
    if (w_inc) mem[wbin[ADDR_W-1:0]] <= data_in;

  always_ff @(posedge write_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      wbin        <= '0;
      wgray       <= '0;
      rq          <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
    end else begin
      wbin        <= wbin_nx;
      wgray       <= wgray_nx;
      rq          <= {rq[S-2:0], rgray};
      // full: writer a whole lap ahead of the synced reader
      full        <= (wgray_nx == (rq[S-1] ^ INV));
      almost_full <= (wcnt_nx >= AF_TH);
      wr_count    <= wcnt_nx;
    end

  assign overflow = write_en & full;

  always_comb begin
    r_inc    = read_en & ~empty;
    rbin_nx  = rbin + {{ADDR_W{1'b0}}, r_inc};
    rgray_nx = b2g(rbin_nx);
    rcnt_nx  = g2b(wq[S-1]) - rbin_nx;
  end

  always_ff @(posedge read_clk or negedge r_rst_n)
    if (!r_rst_n) begin
      rbin         <= '0;
      rgray        <= '0;
      wq           <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      out          <= '0;
      out_valid    <= 1'b0;
    end else begin
      rbin         <= rbin_nx;
      rgray        <= rgray_nx;
      wq           <= {wq[S-2:0], wgray};
      empty        <= (rgray_nx == wq[S-1]);
      almost_empty <= (rcnt_nx <= AE_TH);
      rd_count     <= rcnt_nx;
      out_valid    <= r_inc;
      if (r_inc) out <= mem[rbin[ADDR_W-1:0]];
    end

  assign underflow = read_en & empty;

endmodule

// File: tb/tb_async_fifo_gray.sv
// Bench for async_fifo_gray: vector table, corner sequences and
// randomized traffic at several clock ratios against a queue model.
module tb_async_fifo_gray;

  localparam int DEPTH = 8;

  logic       write_clk = 1'b0;
  logic       read_clk  = 1'b0;
  logic       reset     = 1'b0;
  logic       write_en  = 1'b0;
  logic       read_en   = 1'b0;
  logic [7:0] data_in   = 8'h00;
  logic       full, almost_full, overflow;
  logic       out_valid, empty, almost_empty, underflow;
  logic [3:0] wr_count, rd_count;
  logic [7:0] out;

  int whalf = 5;
  int rhalf = 14;
  int errors = 0;
  int checks = 0;
  logic [7:0] model[$];

  async_fifo_gray #(
    .DATA_W(8), .ADDR_W(3), .SYNC_STAGES(2),
    .AFULL_TH(6), .AEMPTY_TH(1)
  ) dut (
    .write_clk(write_clk), .read_clk(read_clk), .reset(reset),
    .write_en(write_en), .data_in(data_in),
    .full(full), .almost_full(almost_full),
    .wr_count(wr_count), .overflow(overflow),
    .read_en(read_en), .out(out), .out_valid(out_valid),
    .empty(empty), .almost_empty(almost_empty),
    .rd_count(rd_count), .underflow(underflow)
  );

  initial forever #(whalf) write_clk = ~write_clk;
  initial begin
    #2;
    forever #(rhalf) read_clk = ~read_clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rd;
    logic       en;
    logic [7:0] din;
    logic [7:0] e_out;
    logic       e_vld;
    logic       e_flag;
    logic       e_aflag;
    logic [3:0] e_cnt;
    logic       e_xflow;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_rd(input int n, input string nm);
    int k = 0;
    while (rd_count != 4'(n) && k < 40) begin
      @(posedge read_clk);
      #1;
      k++;
    end
    chk(nm, rd_count, n);
  endtask

  task automatic wait_wr(input int n, input string nm);
    int k = 0;
    while (wr_count != 4'(n) && k < 40) begin
      @(posedge write_clk);
      #1;
      k++;
    end
    chk(nm, wr_count, n);
  endtask

  task automatic wr_word(input logic [7:0] d);
    @(negedge write_clk);
    write_en = 1'b1;
    data_in  = d;
    @(negedge write_clk);
    write_en = 1'b0;
  endtask

  task automatic rd_word(input logic [7:0] exp, input string nm);
    @(negedge read_clk);
    read_en = 1'b1;
    @(posedge read_clk);
    #1;
    read_en = 1'b0;
    chk({nm, "_out"}, out, exp);
    chk({nm, "_vld"}, out_valid, 1);
  endtask

  task automatic rand_phase(input int n);
    fork
      begin
        int sent = 0;
        while (sent < n) begin
          @(negedge write_clk);
          write_en = !full && ($urandom_range(9) < 8);
          data_in  = 8'($urandom);
          #1;
          chk("rnd_ovf", overflow, 0);
          chk("rnd_full_cnt", full, wr_count == 4'(DEPTH));
          if (write_en) begin
            @(posedge write_clk);
            model.push_back(data_in);
            sent++;
          end
        end
        @(negedge write_clk);
        write_en = 1'b0;
      end
      begin
        int got = 0;
        int cyc = 0;
        logic rd;
        logic [7:0] exp;
        while (got < n && cyc < 8 * n + 2000) begin
          @(negedge read_clk);
          read_en = !empty && ($urandom_range(9) < 8);
          rd = read_en;
          #1;
          chk("rnd_unf", underflow, 0);
          chk("rnd_empty_cnt", empty, rd_count == 4'd0);
          @(posedge read_clk);
          #1;
          cyc++;
          chk("rnd_valid", out_valid, rd);
          if (rd) begin
            if (model.size() == 0) begin
              chk("rnd_model_nonempty", 0, 1);
            end else begin
              exp = model.pop_front();
              chk("rnd_data", out, exp);
            end
            got++;
          end
        end
        read_en = 1'b0;
        chk("rnd_done", got, n);
      end
    join
  endtask

  initial begin
    int n;
    logic [7:0] d;

    for (int k = 1; k <= 9; k++) begin
      tbl[k-1].rd      = 1'b0;
      tbl[k-1].en      = 1'b1;
      tbl[k-1].din     = (k <= 8) ? 8'(17 * k) : 8'h99;
      tbl[k-1].e_out   = 8'h00;
      tbl[k-1].e_vld   = 1'b0;
      tbl[k-1].e_flag  = (k >= 8);
      tbl[k-1].e_aflag = (k >= 6);
      tbl[k-1].e_cnt   = (k >= 8) ? 4'd8 : 4'(k);
      tbl[k-1].e_xflow = (k == 9);
      tbl[k+8].rd      = 1'b1;
      tbl[k+8].en      = 1'b1;
      tbl[k+8].din     = 8'h00;
      tbl[k+8].e_out   = (k <= 8) ? 8'(17 * k) : 8'h88;
      tbl[k+8].e_vld   = (k <= 8);
      tbl[k+8].e_flag  = (k >= 8);
      tbl[k+8].e_aflag = (k >= 7);
      tbl[k+8].e_cnt   = (k >= 8) ? 4'd0 : 4'(8 - k);
      tbl[k+8].e_xflow = (k == 9);
    end

    #20;
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_wcnt", wr_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_rcnt", rd_count, 0);
    chk("rst_out", out, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_unf", underflow, 0);
    reset = 1'b1;
    repeat (4) @(posedge read_clk);

    for (int i = 0; i < 18; i++) begin
      if (!tbl[i].rd) begin
        @(negedge write_clk);
        write_en = tbl[i].en;
        data_in  = tbl[i].din;
        #1;
        chk($sformatf("v%0d_ovf", i), overflow, tbl[i].e_xflow);
        @(posedge write_clk);
        #1;
        chk($sformatf("v%0d_full", i), full, tbl[i].e_flag);
        chk($sformatf("v%0d_afull", i), almost_full, tbl[i].e_aflag);
        chk($sformatf("v%0d_wcnt", i), wr_count, tbl[i].e_cnt);
      end else begin
        if (i == 9) begin
          @(negedge write_clk);
          write_en = 1'b0;
          wait_rd(8, "fill_visible");
        end
        @(negedge read_clk);
        read_en = tbl[i].en;
        #1;
        chk($sformatf("v%0d_unf", i), underflow, tbl[i].e_xflow);
        @(posedge read_clk);
        #1;
        chk($sformatf("v%0d_out", i), out, tbl[i].e_out);
        chk($sformatf("v%0d_vld", i), out_valid, tbl[i].e_vld);
        chk($sformatf("v%0d_empty", i), empty, tbl[i].e_flag);
        chk($sformatf("v%0d_aempty", i), almost_empty, tbl[i].e_aflag);
        chk($sformatf("v%0d_rcnt", i), rd_count, tbl[i].e_cnt);
      end
    end
    read_en = 1'b0;

    wait_wr(0, "drain_wcnt");
    chk("drain_full", full, 0);
    repeat (4) @(posedge read_clk);
    chk("pre_single_empty", empty, 1);
    @(negedge write_clk);
    write_en = 1'b1;
    data_in  = 8'h5A;
    @(posedge write_clk);
    fork
      begin
        @(negedge write_clk);
        write_en = 1'b0;
      end
    join_none
    n = 0;
    while (empty && n < 10) begin
      @(posedge read_clk);
      #1;
      n++;
    end
    chk("single_latency_le3", (n >= 1 && n <= 3), 1);
    chk("single_rcnt", rd_count, 1);
    chk("single_aempty", almost_empty, 1);
    rd_word(8'h5A, "single");

    for (int it = 0; it < 20; it++) begin
      for (int j = 0; j < 5; j++) begin
        d = 8'($urandom);
        model.push_back(d);
        wr_word(d);
      end
      wait_rd(5, $sformatf("wrap%0d_rcnt5", it));
      for (int j = 0; j < 5; j++)
        rd_word(model.pop_front(), $sformatf("wrap%0d_%0d", it, j));
    end
    wait_wr(0, "wrap_wcnt0");
    chk("wrap_rcnt0", rd_count, 0);
    chk("wrap_empty", empty, 1);

    whalf = 5;  rhalf = 15;
    rand_phase(3334);
    whalf = 15; rhalf = 5;
    rand_phase(3334);
    whalf = 5;  rhalf = 5;
    rand_phase(3332);
    whalf = 5;  rhalf = 14;
    repeat (4) @(posedge read_clk);
    chk("rnd_model_drained", model.size(), 0);

    for (int j = 1; j <= 4; j++)
      wr_word(8'(8'h30 + j));
    wait_rd(4, "mid_rcnt4");
    @(negedge write_clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_empty", empty, 1);
    chk("mid_full", full, 0);
    chk("mid_wcnt", wr_count, 0);
    chk("mid_rcnt", rd_count, 0);
    chk("mid_out", out, 0);
    chk("mid_vld", out_valid, 0);
    chk("mid_afull", almost_full, 0);
    chk("mid_aempty", almost_empty, 1);
    #30;
    reset = 1'b1;
    repeat (4) @(posedge read_clk);
    wr_word(8'hA5);
    wait_rd(1, "post_rst_rcnt1");
    rd_word(8'hA5, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
